mixer_lo_ctrl: RTL and testbench
================================

// Module: mixer_lo_ctrl
// PURPOSE
// Sequencer/configurator for the 2-cycle time-shared real-to-complex mixer. Keeps a phase
// counter in lock-step with the mixer's I/Q multiply slots. Runs an NCO: phase accumulator
// plus quarter-wave sine LUT, driving lo_i/lo_q. Retunes are phase-continuous and atomic
// at sample boundaries through a valid/ready config port.
// PARAMETERS
// DSZ     16  LO sample width, signed
// PSZ     32  phase accumulator width
// LUT_AW  10  quarter-wave LUT address bits; 2^(LUT_AW+2) points per full cycle
// PORTS
// clk        in   1        clock
// reset      in   1        synchronous, active-high; must be the same reset as the mixer
// cfg_valid  in   1        config write request
// cfg_ready  out  1        config write accepted when cfg_valid & cfg_ready
// cfg_addr   in   2        0=FTW, 1=POFF, 2=CTRL, 3=COMMIT
// cfg_data   in   PSZ      write data
// sample_stb out  1        high in the slot where the mixer captures in/lo (its state 0)
// lo_i       out  DSZ      LO in-phase, signed
// lo_q       out  DSZ      LO quadrature, signed
// lo_valid   out  1        lo_i/lo_q hold NCO output (pipeline primed)
// phase_wrap out  1        one-sample pulse when accumulator overflows
// BEHAVIOUR
// - Reset: slot=0, acc=0, active and shadow FTW/POFF/CTRL=0, pipeline cleared;
//   lo_i=lo_q=0, lo_valid=0, sample_stb=0, phase_wrap=0, cfg_ready=1.
// - Slot bit toggles every clk from reset and is never gated. sample_stb=1 when slot==0.
//   This matches the mixer's free-running state bit.
// - lo_i/lo_q/lo_valid/phase_wrap change only on edges leaving slot 1. They are therefore
//   stable across the slot-0 capture edge.
// - NCO step: once per sample, if CTRL[0] (run): acc <= acc + FTW, modulo 2^PSZ.
//   phase_wrap=1 for the sample in which the carry out occurred.
// - theta = (acc + POFF)[PSZ-1 -: LUT_AW+2]. Top 2 bits are the quadrant; the rest index the
//   LUT, mirrored in odd quadrants.
// - LUT[k] = round(A*sin(2*pi*(k+0.5)/2^(LUT_AW+2))), A=2^(DSZ-1)-1. The half-step offset
//   means there is no endpoint entry and the folding is exactly symmetric.
// - lo_i = A*cos(theta). lo_q = -A*sin(theta) when CTRL[2]=0 (down-conversion);
//   +A*sin(theta) when CTRL[2]=1. Negation never overflows because |LUT| <= A.
// - Latency: a new acc value reaches lo_i/lo_q 2 samples (4 clk) later. lo_valid rises
//   with the first such output after reset or after CTRL[0] goes 0->1.
// - With CTRL[0]=0 the accumulator freezes and the LO holds theta(acc+POFF) (static LO).
//   lo_valid is held.
// - Config: writes to addr 0-2 go to shadow registers and are accepted immediately.
//   An addr 3 write arms a commit; cfg_data[0]=1 also requests acc clear.
// - Armed commit: cfg_ready=0. At the next edge leaving slot 1, shadow is copied to active
//   (and acc<=0 if requested) before that sample's NCO step. cfg_ready returns to 1 on the
//   following clk.
// - Simultaneous commit application and a cfg_valid at addr 0-2: the write is not accepted
//   because cfg_ready=0. Retries are the master's job.
// - Reset during an armed commit: the commit is discarded and all registers return to
//   reset values.
// - CTRL[1] (pending sync clear) is self-clearing: acc<=0 at the next commit, then the
//   shadow bit is cleared.
// STRUCTURE
// - Shared package mixer_pkg: DSZ, CFG_ADDR_* constants (FTW=0, POFF=1, CTRL=2, COMMIT=3),
//   CTRL bit indices (RUN=0, CLR=1, QINV=2).
// - One sub-module: nco_quarter_lut, a registered-read ROM (LUT_AW-bit address, DSZ-1-bit
//   unsigned data). Generated by a function at elaboration.
// TESTING
// - Reset, no config: 8 clk -> sample_stb toggles 0,1,0,1 starting high 1 clk after reset;
//   lo_i=lo_q=0, lo_valid=0, cfg_ready=1.
// - Static LO: FTW=0, POFF=0, CTRL=1, commit -> lo_i=32767, lo_q=-25; held every sample;
//   lo_valid=1 four clk after the commit is applied.
// - FTW=2^30, CTRL=1 -> lo_i sequence 32767,-25,-32767,25 repeating.
//   phase_wrap pulses every 4th sample.
// - Same test with CTRL=5 (QINV) -> lo_q sign flips relative to the CTRL=1 run,
//   sample for sample.
// - Commit with cfg_valid held to addr 0 -> cfg_ready=0 for the commit window; the FTW write
//   is accepted only after ready returns. The output frequency changes exactly 2 samples
//   after application, with no phase jump.
// - Reset asserted 1 clk after an armed commit -> no shadow values applied;
//   all outputs at reset values.
// - Mixer co-sim: in=16384 const, FTW=0 -> mixer out_i~=16383, out_q~=-12 stable;
//   verifies slot alignment.

Source files
------------

// File: rtl/mixer_pkg.sv
// Shared constants for the time-shared mixer and its LO controller.
// Holds the config address map, CTRL bit positions and the commit FSM states.
package mixer_pkg;

   localparam int DSZ    = 16;
   localparam int PSZ    = 32;
   localparam int LUT_AW = 10;

   localparam logic [1:0] CFG_ADDR_FTW    = 2'd0;
   localparam logic [1:0] CFG_ADDR_POFF   = 2'd1;
   localparam logic [1:0] CFG_ADDR_CTRL   = 2'd2;
   localparam logic [1:0] CFG_ADDR_COMMIT = 2'd3;

   localparam int CTRL_RUN  = 0;
   localparam int CTRL_CLR  = 1;
   localparam int CTRL_QINV = 2;

   typedef enum logic [1:0] {
      CFG_IDLE,
      CFG_ARMED,
      CFG_DONE
   } cfg_state_t;

endpackage

// File: rtl/nco_quarter_lut.sv
// Registered-read quarter-wave sine ROM. Entries sit on half-step sample points,
// so the table folds symmetrically with no endpoint entry.
module nco_quarter_lut #(
   parameter int AW = 10,
   parameter int DW = 15
) (
   input  logic          clk,
   input  logic          en,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   localparam int DEPTH = 1 << AW;

   // Sine by Taylor series over [0, pi/2], rounded to nearest, evaluated at elaboration.
   function automatic int lut_value(int k);
      real pi;
      real x;
      real term;
      real sum;
      pi   = 3.14159265358979323846;
      x    = 2.0 * pi * (real'(k) + 0.5) / real'(DEPTH * 4);
      term = x;
      sum  = x;
      for (int n = 1; n < 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return $rtoi(sum * real'((1 << DW) - 1) + 0.5);
   endfunction

   logic [DW-1:0] rom [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_rom
      localparam logic [DW-1:0] ENTRY = DW'(lut_value(k));
      assign rom[k] = ENTRY;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         data <= rom[addr];
      end
   end

endmodule

// File: rtl/mixer_lo_ctrl.sv
// LO sequencer for the 2-cycle time-shared mixer: slot tracking, NCO with
// quarter-wave LUT, and phase-continuous retunes applied at sample boundaries.
module mixer_lo_ctrl #(
   parameter int DSZ    = mixer_pkg::DSZ,
   parameter int PSZ    = mixer_pkg::PSZ,
   parameter int LUT_AW = mixer_pkg::LUT_AW
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           cfg_valid,
   output logic           cfg_ready,
   input  logic [1:0]     cfg_addr,
   input  logic [PSZ-1:0] cfg_data,
   output logic           sample_stb,
   output logic [DSZ-1:0] lo_i,
   output logic [DSZ-1:0] lo_q,
   output logic           lo_valid,
   output logic           phase_wrap
);
   import mixer_pkg::*;

   localparam int TW = LUT_AW + 2;

   logic              slot;
   cfg_state_t        cfg_state;
   logic [PSZ-1:0]    ftw_s;
   logic [PSZ-1:0]    poff_s;
   logic [2:0]        ctrl_s;
   logic              clr_req;
   logic [PSZ-1:0]    ftw_a;
   logic [PSZ-1:0]    poff_a;
   logic              run_a;
   logic              qinv_a;
   logic [PSZ-1:0]    acc;

   logic              s1_valid;
   logic [1:0]        s1_quad;
   logic              s1_qinv;
   logic [DSZ-2:0]    sin_mag;
   logic [DSZ-2:0]    cos_mag;

   logic              apply;
   logic              run_n;
   logic [PSZ-1:0]    ftw_n;
   logic [PSZ-1:0]    acc_base;
   logic [PSZ-1:0]    acc_sum;
   logic              carry;
   logic [TW-1:0]     theta;
   logic [LUT_AW-1:0] sin_addr;
   logic [LUT_AW-1:0] cos_addr;
   logic signed [DSZ-1:0] sin_v;
   logic signed [DSZ-1:0] cos_v;
   logic signed [DSZ-1:0] lo_q_n;

   // The edge leaving slot 1 ends a sample; a pending commit lands there, ahead of that step.
   always_comb begin
      apply    = slot && (cfg_state == CFG_ARMED);
      run_n    = apply ? ctrl_s[CTRL_RUN] : run_a;
      ftw_n    = apply ? ftw_s : ftw_a;
      acc_base = (apply && (clr_req || ctrl_s[CTRL_CLR])) ? '0 : acc;
      {carry, acc_sum} = {1'b0, acc_base} + {1'b0, ftw_n & {PSZ{run_n}}};
   end

   assign theta    = TW'((acc + poff_a) >> (PSZ - TW));
   assign sin_addr = theta[LUT_AW-1:0] ^ {LUT_AW{theta[TW-2]}};
   assign cos_addr = theta[LUT_AW-1:0] ^ {LUT_AW{~theta[TW-2]}};

   nco_quarter_lut #(.AW(LUT_AW), .DW(DSZ-1)) u_sin_lut (
      .clk  (clk),
      .en   (slot),
      .addr (sin_addr),
      .data (sin_mag)
   );

   nco_quarter_lut #(.AW(LUT_AW), .DW(DSZ-1)) u_cos_lut (
      .clk  (clk),
      .en   (slot),
      .addr (cos_addr),
      .data (cos_mag)
   );

   // Quadrant sign restoration; QINV picks up- or down-conversion for the Q branch.
   always_comb begin
      sin_v = $signed({1'b0, sin_mag});
      if (s1_quad[1]) sin_v = -sin_v;
      cos_v = $signed({1'b0, cos_mag});
      if (s1_quad[1] ^ s1_quad[0]) cos_v = -cos_v;
      lo_q_n = s1_qinv ? sin_v : -sin_v;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot       <= 1'b0;
         sample_stb <= 1'b0;
         cfg_state  <= CFG_IDLE;
         cfg_ready  <= 1'b1;
         ftw_s      <= '0;
         poff_s     <= '0;
         ctrl_s     <= '0;
         clr_req    <= 1'b0;
         ftw_a      <= '0;
         poff_a     <= '0;
         run_a      <= 1'b0;
         qinv_a     <= 1'b0;
         acc        <= '0;
         phase_wrap <= 1'b0;
         s1_valid   <= 1'b0;
         s1_quad    <= '0;
         s1_qinv    <= 1'b0;
         lo_i       <= '0;
         lo_q       <= '0;
         lo_valid   <= 1'b0;
      end else begin
         slot       <= ~slot;
         sample_stb <= slot;

         case (cfg_state)
            CFG_IDLE: begin
               if (cfg_valid) begin
                  case (cfg_addr)
                     CFG_ADDR_FTW:  ftw_s  <= cfg_data;
                     CFG_ADDR_POFF: poff_s <= cfg_data;
                     CFG_ADDR_CTRL: ctrl_s <= cfg_data[2:0];
                     CFG_ADDR_COMMIT: begin
                        clr_req   <= cfg_data[0];
                        cfg_state <= CFG_ARMED;
                        cfg_ready <= 1'b0;
                     end
                  endcase
               end
            end
            CFG_ARMED: begin
               if (apply) begin
                  ftw_a            <= ftw_s;
                  poff_a           <= poff_s;
                  run_a            <= ctrl_s[CTRL_RUN];
                  qinv_a           <= ctrl_s[CTRL_QINV];
                  ctrl_s[CTRL_CLR] <= 1'b0;
                  clr_req          <= 1'b0;
                  cfg_state        <= CFG_DONE;
               end
            end
            CFG_DONE: begin
               cfg_state <= CFG_IDLE;
               cfg_ready <= 1'b1;
            end
            default: begin
               cfg_state <= CFG_IDLE;
               cfg_ready <= 1'b1;
            end
         endcase

         // Two-sample pipeline: accumulate, LUT read, then fold to signed LO outputs.
         if (slot) begin
            acc        <= acc_sum;
            phase_wrap <= carry;
            s1_valid   <= s1_valid | run_a;
            s1_quad    <= theta[TW-1:TW-2];
            s1_qinv    <= qinv_a;
            if (s1_valid) begin
               lo_i     <= cos_v;
               lo_q     <= lo_q_n;
               lo_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mixer_lo_ctrl.sv
// Directed bench for mixer_lo_ctrl: a cycle table for reset, static and
// quarter-rate LO, then hand sequences for QINV, commit windows and reset abort.
module tb_mixer_lo_ctrl;

   localparam logic [31:0] FTW_Q = 32'h4000_0000;
   localparam logic [31:0] FTW_H = 32'h8000_0000;

   logic               clk       = 1'b0;
   logic               reset     = 1'b1;
   logic               cfg_valid = 1'b0;
   logic [1:0]         cfg_addr  = 2'd0;
   logic [31:0]        cfg_data  = 32'd0;
   logic               cfg_ready;
   logic               sample_stb;
   logic signed [15:0] lo_i;
   logic signed [15:0] lo_q;
   logic               lo_valid;
   logic               phase_wrap;

   mixer_lo_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .sample_stb (sample_stb),
      .lo_i       (lo_i),
      .lo_q       (lo_q),
      .lo_valid   (lo_valid),
      .phase_wrap (phase_wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [1:0]  a;
      logic [31:0] d;
      logic        stb;
      logic        rdy;
      logic        lv;
      logic        wr;
      int          li;
      int          lq;
   } vec_t;

   vec_t vecs[$];
   int   n_applied     = 0;
   int   n_miscompares = 0;
   int   cyc           = 0;

   function automatic void add(logic v, logic [1:0] a, logic [31:0] d, logic stb,
                               logic rdy, logic lv, logic wr, int li, int lq);
      vec_t t;
      t.v = v; t.a = a; t.d = d; t.stb = stb; t.rdy = rdy;
      t.lv = lv; t.wr = wr; t.li = li; t.lq = lq;
      vecs.push_back(t);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(int target);
      while (cyc < target) tick();
   endtask

   task automatic applyStimulus(logic v, logic [1:0] a, logic [31:0] d);
      cfg_valid = v;
      cfg_addr  = a;
      cfg_data  = d;
      tick();
   endtask

   task automatic cfg_write(logic [1:0] a, logic [31:0] d);
      applyStimulus(1'b1, a, d);
      cfg_valid = 1'b0;
   endtask

   task automatic checkOutput(string name, int actual, int expected);
      n_applied++;
      if (actual != expected) begin
         n_miscompares++;
         $display("[TB] FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   task automatic check_lo(string name, int ei, int eq);
      checkOutput({name, ".lo_i"}, int'(lo_i), ei);
      checkOutput({name, ".lo_q"}, int'(lo_q), eq);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // v a d                stb rdy lv wr  lo_i    lo_q
      add(0, 0, 0,             0, 1, 0, 0,      0,      0);
      add(0, 0, 0,             1, 1, 0, 0,      0,      0);
      add(0, 0, 0,             0, 1, 0, 0,      0,      0);
      add(0, 0, 0,             1, 1, 0, 0,      0,      0);
      add(1, 0, 0,             0, 1, 0, 0,      0,      0);
      add(1, 1, 0,             1, 1, 0, 0,      0,      0);
      add(1, 2, 1,             0, 1, 0, 0,      0,      0);
      add(1, 3, 0,             1, 0, 0, 0,      0,      0);
      add(0, 0, 0,             0, 0, 0, 0,      0,      0);
      add(0, 0, 0,             1, 0, 0, 0,      0,      0);
      add(0, 0, 0,             0, 1, 0, 0,      0,      0);
      add(0, 0, 0,             1, 1, 0, 0,      0,      0);
      add(0, 0, 0,             0, 1, 0, 0,      0,      0);
      add(0, 0, 0,             1, 1, 1, 0,  32767,    -25);
      add(0, 0, 0,             0, 1, 1, 0,  32767,    -25);
      add(0, 0, 0,             1, 1, 1, 0,  32767,    -25);
      add(1, 0, FTW_Q,         0, 1, 1, 0,  32767,    -25);
      add(1, 2, 1,             1, 1, 1, 0,  32767,    -25);
      add(1, 3, 1,             0, 0, 1, 0,  32767,    -25);
      add(0, 0, 0,             1, 0, 1, 0,  32767,    -25);
      add(0, 0, 0,             0, 1, 1, 0,  32767,    -25);
      add(0, 0, 0,             1, 1, 1, 0,  32767,    -25);
      add(0, 0, 0,             0, 1, 1, 0,  32767,    -25);
      add(0, 0, 0,             1, 1, 1, 0,    -25, -32767);
      add(0, 0, 0,             0, 1, 1, 0,    -25, -32767);
      add(0, 0, 0,             1, 1, 1, 1, -32767,     25);
      add(0, 0, 0,             0, 1, 1, 1, -32767,     25);
      add(0, 0, 0,             1, 1, 1, 0,     25,  32767);
      add(0, 0, 0,             0, 1, 1, 0,     25,  32767);
      add(0, 0, 0,             1, 1, 1, 0,  32767,    -25);
      add(0, 0, 0,             0, 1, 1, 0,  32767,    -25);
      add(0, 0, 0,             1, 1, 1, 0,    -25, -32767);

      repeat (3) tick();
      checkOutput("reset.sample_stb", int'(sample_stb), 0);
      checkOutput("reset.cfg_ready",  int'(cfg_ready),  1);
      checkOutput("reset.lo_valid",   int'(lo_valid),   0);
      checkOutput("reset.phase_wrap", int'(phase_wrap), 0);
      check_lo("reset", 0, 0);

      reset = 1'b0;
      cyc   = 0;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].v, vecs[i].a, vecs[i].d);
         checkOutput($sformatf("vec%0d.sample_stb", i + 1), int'(sample_stb), int'(vecs[i].stb));
         checkOutput($sformatf("vec%0d.cfg_ready", i + 1),  int'(cfg_ready),  int'(vecs[i].rdy));
         checkOutput($sformatf("vec%0d.lo_valid", i + 1),   int'(lo_valid),   int'(vecs[i].lv));
         checkOutput($sformatf("vec%0d.phase_wrap", i + 1), int'(phase_wrap), int'(vecs[i].wr));
         check_lo($sformatf("vec%0d", i + 1), vecs[i].li, vecs[i].lq);
      end
      cfg_valid = 1'b0;

      // Same quarter-rate sweep with QINV: lo_q flips sign sample for sample.
      cfg_write(2'd2, 32'd5);
      cfg_write(2'd3, 32'd1);
      run_to(40); check_lo("qinv.s0",     -25,  32767);
      run_to(42); check_lo("qinv.s1",  -32767,    -25);
      run_to(44); check_lo("qinv.s2",      25, -32767);
      run_to(46); check_lo("qinv.s3",   32767,     25);

      // FTW write held across a commit window is only taken once ready returns.
      cfg_write(2'd3, 32'd0);
      checkOutput("win.ready_armed", int'(cfg_ready), 0);
      cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = FTW_H;
      tick();
      checkOutput("win.ready_apply", int'(cfg_ready), 0);
      tick();
      checkOutput("win.ready_back", int'(cfg_ready), 1);
      tick();
      cfg_valid = 1'b0;
      cfg_write(2'd3, 32'd0);
      checkOutput("retune.ready_armed", int'(cfg_ready), 0);
      tick();
      check_lo("retune.s0", 25, -32767);
      checkOutput("retune.wrap_s0", int'(phase_wrap), 0);
      run_to(54);
      check_lo("retune.s1", 32767, 25);
      checkOutput("retune.wrap_s1", int'(phase_wrap), 1);
      run_to(56); check_lo("retune.s2", -32767, -25);
      run_to(58); check_lo("retune.s3",  32767,  25);

      // Reset one clock after arming discards the commit and the shadow registers.
      cfg_write(2'd1, FTW_Q);
      cfg_write(2'd3, 32'd0);
      checkOutput("abort.ready_armed", int'(cfg_ready), 0);
      reset = 1'b1;
      tick();
      checkOutput("abort.sample_stb", int'(sample_stb), 0);
      checkOutput("abort.cfg_ready",  int'(cfg_ready),  1);
      checkOutput("abort.lo_valid",   int'(lo_valid),   0);
      checkOutput("abort.phase_wrap", int'(phase_wrap), 0);
      check_lo("abort", 0, 0);
      reset = 1'b0;
      cyc   = 0;
      run_to(4);
      checkOutput("abort.idle_valid", int'(lo_valid), 0);
      cfg_write(2'd3, 32'd0);
      run_to(16);
      checkOutput("abort.post_lo_valid", int'(lo_valid),  0);
      checkOutput("abort.post_ready",    int'(cfg_ready), 1);
      checkOutput("abort.post_wrap",     int'(phase_wrap), 0);
      check_lo("abort.post", 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
      $finish;
   end

endmodule
